// File: rtl/ex_pkg.sv
// Shared types for the multi-cycle execute unit: operation codes, flag layout, FSM states.
package ex_pkg;

  typedef enum logic [3:0] {
    PASS_B = 4'd0,
    ADD    = 4'd1,
    SUB    = 4'd2,
    AND    = 4'd3,
    ORR    = 4'd4,
    EOR    = 4'd5,
    LSL    = 4'd6,
    LSR    = 4'd7,
    ASR    = 4'd8,
    MUL    = 4'd9,
    UMULH  = 4'd10
  } ex_op_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic carry_out;
  } ex_flags_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    MUL_WB  = 2'd2
  } ex_state_t;

  function automatic logic is_mul(ex_op_t op);
    return (op == MUL) || (op == UMULH);
  endfunction

endpackage

// File: rtl/ex_unit_mc_if.sv
// Issue/result bundle between ID/EX and the execute unit; master drives operations, slave is the unit.
interface ex_unit_mc_if #(
  parameter int WIDTH = 64
);
  import ex_pkg::*;

  localparam int SHAMT_W = $clog2(WIDTH);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  ex_op_t             op;
  logic [WIDTH-1:0]   data_a;
  logic [WIDTH-1:0]   data_b;
  logic [SHAMT_W-1:0] shamt;
  logic               set_flags_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  ex_flags_t          flags;
  logic               set_flags_out;
  logic               busy;

  modport master (
    output flush, in_valid, op, data_a, data_b, shamt, set_flags_in, out_ready,
    input  in_ready, out_valid, result, flags, set_flags_out, busy
  );

  modport slave (
    input  flush, in_valid, op, data_a, data_b, shamt, set_flags_in, out_ready,
    output in_ready, out_valid, result, flags, set_flags_out, busy
  );

endinterface

// File: rtl/ex_unit_mc_iter_mult.sv
// Iterative unsigned multiplier: retires MUL_BITS multiplier bits per run cycle into a
// full-width 2*WIDTH accumulator; last_o flags the final step.
module iter_mult #(
  parameter int WIDTH    = 64,
  parameter int MUL_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 run_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  always_comb begin
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      count_d  = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
    end else if (run_i) begin
      // multiplicand is pre-shifted, so each step is a narrow multiply plus an add
      acc_d    = acc_q + mcand_q * {{(2*WIDTH-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};
      count_d  = count_q + CNT_W'(1);
      mcand_d  = mcand_q << MUL_BITS;
      mplier_d = mplier_q >> MUL_BITS;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign last_o    = (count_q == CNT_W'(STEPS - 1));
  assign product_o = acc_q;

endmodule

// File: rtl/ex_unit_mc.sv
// Multi-cycle execute unit: single-cycle ALU/shifter plus iterative multiply behind a
// valid/ready handshake, with a registered result stage.
//
// state   | meaning
// IDLE    | accepting ops; single-cycle results load directly
// MUL_RUN | multiplier retiring partial products
// MUL_WB  | product ready, waiting for a free output register
module ex_unit_mc
  import ex_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MUL_BITS = 1
) (
  input logic         clk,
  input logic         reset_n,
  ex_unit_mc_if.slave bus
);

  ex_state_t          state_q, state_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  ex_flags_t          flags_q, flags_d;
  logic               sfo_q, sfo_d;
  logic               hi_q, hi_d;
  logic               sf_mul_q, sf_mul_d;

  logic               accept, out_free;
  logic               mul_start, mul_run, mul_last;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   b_eff, alu_res, mul_res;
  logic [WIDTH:0]     sum;
  ex_flags_t          alu_flags, mul_flags;

  always_comb begin
    b_eff     = (bus.op == SUB) ? ~bus.data_b : bus.data_b;
    sum       = {1'b0, bus.data_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (bus.op == SUB)};
    alu_res   = bus.data_b;
    alu_flags = '0;
    case (bus.op)
      ADD, SUB: begin
        alu_res             = sum[WIDTH-1:0];
        alu_flags.carry_out = sum[WIDTH];
        alu_flags.overflow  = (bus.data_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                              (sum[WIDTH-1] != bus.data_a[WIDTH-1]);
      end
      AND:     alu_res = bus.data_a & bus.data_b;
      ORR:     alu_res = bus.data_a | bus.data_b;
      EOR:     alu_res = bus.data_a ^ bus.data_b;
      LSL:     alu_res = bus.data_a << bus.shamt;
      LSR:     alu_res = bus.data_a >> bus.shamt;
      ASR:     alu_res = $unsigned($signed(bus.data_a) >>> bus.shamt);
      default: alu_res = bus.data_b;
    endcase
    alu_flags.negative = alu_res[WIDTH-1];
    alu_flags.zero     = (alu_res == '0);
  end

  always_comb begin
    mul_res            = hi_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
    mul_flags          = '0;
    mul_flags.negative = mul_res[WIDTH-1];
    mul_flags.zero     = (mul_res == '0);
  end

  assign bus.in_ready = (state_q == IDLE) && (!valid_q || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_free     = !valid_q || bus.out_ready;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q && !bus.out_ready;
    result_d  = result_q;
    flags_d   = flags_q;
    sfo_d     = sfo_q;
    hi_d      = hi_q;
    sf_mul_d  = sf_mul_q;
    mul_start = 1'b0;
    mul_run   = 1'b0;
    if (bus.flush) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul(bus.op)) begin
              mul_start = 1'b1;
              hi_d      = (bus.op == UMULH);
              sf_mul_d  = bus.set_flags_in;
              state_d   = MUL_RUN;
            end else begin
              valid_d  = 1'b1;
              result_d = alu_res;
              flags_d  = alu_flags;
              sfo_d    = bus.set_flags_in;
            end
          end
        end
        MUL_RUN: begin
          mul_run = 1'b1;
          if (mul_last) state_d = MUL_WB;
        end
        MUL_WB: begin
          if (out_free) begin
            valid_d  = 1'b1;
            result_d = mul_res;
            flags_d  = mul_flags;
            sfo_d    = sf_mul_q;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      sfo_q    <= 1'b0;
      hi_q     <= 1'b0;
      sf_mul_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      sfo_q    <= sfo_d;
      hi_q     <= hi_d;
      sf_mul_q <= sf_mul_d;
    end
  end

  iter_mult #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (mul_start),
    .run_i     (mul_run),
    .a_i       (bus.data_a),
    .b_i       (bus.data_b),
    .last_o    (mul_last),
    .product_o (mul_prod)
  );

  assign bus.out_valid     = valid_q;
  assign bus.result        = result_q;
  assign bus.flags         = flags_q;
  assign bus.set_flags_out = sfo_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ex_unit_mc.sv
// Bench for ex_unit_mc: directed scenarios plus randomized traffic checked against a
// transaction-level reference model; a MUL_BITS=4 instance checks multiply latency.
module tb_ex_unit_mc;
  import ex_pkg::*;

  logic        clk;
  logic        rst_n, flush, in_valid, en4, out_ready, sf_in;
  logic [3:0]  op_v;
  logic [63:0] a, b;
  logic [5:0]  sh;

  int n_checks = 0;
  int n_err    = 0;

  ex_unit_mc_if #(.WIDTH(64)) bus1 ();
  ex_unit_mc_if #(.WIDTH(64)) bus4 ();

  assign bus1.flush        = flush;
  assign bus1.in_valid     = in_valid;
  assign bus1.op           = ex_op_t'(op_v);
  assign bus1.data_a       = a;
  assign bus1.data_b       = b;
  assign bus1.shamt        = sh;
  assign bus1.set_flags_in = sf_in;
  assign bus1.out_ready    = out_ready;

  assign bus4.flush        = flush;
  assign bus4.in_valid     = in_valid & en4;
  assign bus4.op           = ex_op_t'(op_v);
  assign bus4.data_a       = a;
  assign bus4.data_b       = b;
  assign bus4.shamt        = sh;
  assign bus4.set_flags_in = sf_in;
  assign bus4.out_ready    = out_ready;

  ex_unit_mc #(.WIDTH(64), .MUL_BITS(1)) dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1));
  ex_unit_mc #(.WIDTH(64), .MUL_BITS(4)) dut4 (.clk(clk), .reset_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending result plus a multiply in flight counted in edges
  logic         m_valid, m_sf, m_hi, m_msf;
  logic [63:0]  m_result;
  logic [3:0]   m_flags;
  logic [127:0] m_prod;
  int           m_phase, m_cnt;

  function automatic logic fits64(input logic [65:0] s);
    return (s[65:63] == 3'b000) || (s[65:63] == 3'b111);
  endfunction

  task automatic ref_alu(input logic [3:0] opc, input logic [63:0] x, input logic [63:0] y,
                         input logic [5:0] s, output logic [63:0] r, output logic [3:0] f);
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (opc)
      4'd1: begin
        r = x + y;
        c = (r < x);
        v = !fits64({{2{x[63]}}, x} + {{2{y[63]}}, y});
      end
      4'd2: begin
        r = x - y;
        c = (x >= y);
        v = !fits64({{2{x[63]}}, x} - {{2{y[63]}}, y});
      end
      4'd3: r = x & y;
      4'd4: r = x | y;
      4'd5: r = x ^ y;
      4'd6: r = x << s;
      4'd7: r = x >> s;
      4'd8: r = (x >> s) | (x[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> s) : 64'd0);
      default: r = y;
    endcase
    f = {r[63], (r == 64'd0), v, c};
  endtask

  task automatic model_edge(input logic r_n, input logic fl, input logic iv, input logic [3:0] opc,
                            input logic [63:0] x, input logic [63:0] y, input logic [5:0] s,
                            input logic sf, input logic ordy);
    logic free, acc;
    logic [63:0] r;
    logic [3:0] f;
    if (!r_n) begin
      m_valid = 0; m_result = '0; m_flags = '0; m_sf = 0; m_phase = 0; m_cnt = 0;
    end else begin
      free = !m_valid || ordy;
      acc  = iv && (m_phase == 0) && free && !fl;
      if (fl) begin
        m_valid = 0;
        m_phase = 0;
      end else begin
        if (m_valid && ordy) m_valid = 0;
        if (m_phase == 1) begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end else if (m_phase == 2) begin
          if (free) begin
            r = m_hi ? m_prod[127:64] : m_prod[63:0];
            m_result = r;
            m_flags  = {r[63], (r == 64'd0), 2'b00};
            m_sf     = m_msf;
            m_valid  = 1;
            m_phase  = 0;
          end
        end else if (acc) begin
          if (opc == 4'd9 || opc == 4'd10) begin
            m_prod  = {64'd0, x} * {64'd0, y};
            m_hi    = (opc == 4'd10);
            m_msf   = sf;
            m_phase = 1;
            m_cnt   = 64;
          end else begin
            ref_alu(opc, x, y, s, r, f);
            m_result = r;
            m_flags  = f;
            m_sf     = sf;
            m_valid  = 1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    logic r_n, fl, iv, sf, ordy;
    logic [3:0] o;
    logic [63:0] x, y;
    logic [5:0] s;
    #1;
    r_n = rst_n; fl = flush; iv = in_valid; o = op_v; x = a; y = b; s = sh; sf = sf_in; ordy = out_ready;
    check_val("in_ready", bus1.in_ready, (m_phase == 0) && (!m_valid || ordy) && !fl);
    @(posedge clk);
    #1;
    model_edge(r_n, fl, iv, o, x, y, s, sf, ordy);
    check_val("out_valid", bus1.out_valid, m_valid);
    check_val("result", bus1.result, m_result);
    check_val("flags", bus1.flags, m_flags);
    check_val("set_flags_out", bus1.set_flags_out, m_sf);
    check_val("busy", bus1.busy, m_phase != 0);
  endtask

  task automatic do_mul(input logic [3:0] opc, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_r);
    int lat1, lat4;
    logic seen4;
    logic [63:0] r4;
    lat1 = 0; lat4 = 0; seen4 = 0; r4 = '0;
    op_v = opc; a = x; b = y; sf_in = 1; out_ready = 1; in_valid = 1; en4 = 1;
    #1;
    check_val("mul4_in_ready", bus4.in_ready, 1'b1);
    tick();
    in_valid = 0; en4 = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (!seen4 && bus4.out_valid) begin
        seen4 = 1; lat4 = k; r4 = bus4.result;
      end
      if (bus1.out_valid) begin
        lat1 = k;
        break;
      end
    end
    check_val("mul1_latency", lat1, 64 / 1 + 1);
    check_val("mul1_result", bus1.result, exp_r);
    check_val("mul4_latency", lat4, 64 / 4 + 1);
    check_val("mul4_result", r4, exp_r);
    tick();
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    m_valid = 0; m_result = '0; m_flags = '0; m_sf = 0; m_hi = 0; m_msf = 0;
    m_prod = '0; m_phase = 0; m_cnt = 0;
    rst_n = 0; flush = 0; in_valid = 0; en4 = 0; out_ready = 1; sf_in = 0;
    op_v = 4'd0; a = '0; b = '0; sh = '0;
    tick();
    tick();
    rst_n = 1;
    tick();

    // ADD overflow into the sign bit
    op_v = 4'd1; a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; sf_in = 1; in_valid = 1;
    tick();
    check_val("add_result", bus1.result, 64'h8000_0000_0000_0000);
    check_val("add_flags", bus1.flags, 4'b1010);

    op_v = 4'd2; a = 64'd5; b = 64'd5;
    tick();
    check_val("sub_result", bus1.result, 64'd0);
    check_val("sub_flags", bus1.flags, 4'b0101);
    op_v = 4'd8; a = 64'h8000_0000_0000_0000; sh = 6'd4;
    tick();
    check_val("asr_result", bus1.result, 64'hF800_0000_0000_0000);
    op_v = 4'd7;
    tick();
    check_val("lsr_result", bus1.result, 64'h0800_0000_0000_0000);
    in_valid = 0;
    tick();

    do_mul(4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    do_mul(4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);

    // Backpressure: pending ADD held while another op waits, then swap with no bubble
    out_ready = 0; op_v = 4'd1; a = 64'd10; b = 64'd20; in_valid = 1;
    tick();
    op_v = 4'd5; a = 64'h1234; b = 64'h4321;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("bp_result_stable", bus1.result, 64'd30);
    end
    out_ready = 1; op_v = 4'd4; a = 64'hF0; b = 64'h0F;
    tick();
    check_val("bp_swap_valid", bus1.out_valid, 1'b1);
    check_val("bp_swap_result", bus1.result, 64'hFF);
    in_valid = 0;
    tick();

    // Flush on cycle 30 of a multiply
    op_v = 4'd9; a = 64'd123; b = 64'd456; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 29; i++) tick();
    flush = 1;
    tick();
    flush = 0;
    #1;
    check_val("flush_busy", bus1.busy, 1'b0);
    check_val("flush_out_valid", bus1.out_valid, 1'b0);
    check_val("flush_in_ready", bus1.in_ready, 1'b1);
    op_v = 4'd1; a = 64'd1; b = 64'd2; in_valid = 1;
    tick();
    check_val("post_flush_add", bus1.result, 64'd3);
    in_valid = 0;
    tick();

    // Reset during MUL_RUN
    op_v = 4'd9; a = 64'd99; b = 64'd77; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    check_val("rst_out_valid", bus1.out_valid, 1'b0);
    check_val("rst_result", bus1.result, 64'd0);
    check_val("rst_flags", bus1.flags, 4'd0);
    check_val("rst_busy", bus1.busy, 1'b0);
    check_val("rst_sfo", bus1.set_flags_out, 1'b0);
    do_mul(4'd9, 64'd3, 64'd7, 64'd21);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op_v      = 4'($urandom_range(0, 15));
      if ((op_v == 4'd9 || op_v == 4'd10) && $urandom_range(0, 3) != 0) op_v = 4'd2;
      a     = pick_operand();
      b     = pick_operand();
      sh    = 6'($urandom_range(0, 63));
      sf_in = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
